// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the ARM immediate encoder: field widths, FSM states
// and the 32-bit rotate-left helper used by every rotation checker.
package imm_encoder_pkg;

  localparam int ROT_W  = 4;
  localparam int IMM8_W = 8;
  localparam int SHOP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Rotate left by amount (0..31). The right-shift distance is (32-amount)
  // mod 32, which is the 5-bit negation; amount=0 degenerates to value|value.
  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
    return (value << amount) | (value >> (5'd0 - amount));
  endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Combinational test of one rotation: rotating the value left by 2*r undoes
// the decoder's ROR, so the candidate hits when only its low byte is set.
module imm_rot_check
  import imm_encoder_pkg::*;
(
  input  logic [31:0]       i_value,
  input  logic [ROT_W-1:0]  i_rot,
  output logic              o_hit,
  output logic [IMM8_W-1:0] o_imm8
);

  logic [31:0] w_cand;

  assign w_cand = rol32(i_value, {i_rot, 1'b0});
  assign o_hit  = (w_cand[31:8] == 24'd0);
  assign o_imm8 = w_cand[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative encoder of a 32-bit constant into the ARM {rotate_imm, immed_8}
// immediate form. ROT_PER_CYCLE rotations are tested per SEARCH cycle; the
// lowest hitting rotation is reported. Optional macro IMM_ENC_INVERT_EN also
// searches ~value (MVN/BIC form) and flags such results with 'inverted'.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              encodable,
  output logic [ROT_W-1:0]  rotate_imm,
  output logic [IMM8_W-1:0] immed_8,
  output logic [SHOP_W-1:0] shift_operand,
  output logic              inverted
);

  localparam logic [ROT_W-1:0] K_STEP = ROT_W'(ROT_PER_CYCLE);
  localparam logic [ROT_W-1:0] K_LAST = ROT_W'(16 - ROT_PER_CYCLE);

  state_e              r_state;
  state_e              w_next_state;
  logic [31:0]         r_value;
  logic [ROT_W-1:0]    r_k;
  logic                r_encodable;
  logic [ROT_W-1:0]    r_rot;
  logic [IMM8_W-1:0]   r_imm8;

  logic                w_accept;
  logic                w_last;
  logic                w_any;
  logic [ROT_W-1:0]    w_sel_rot;
  logic [IMM8_W-1:0]   w_sel_imm8;
  logic                w_sel_inv;

  logic [ROT_W-1:0]    w_rot  [ROT_PER_CYCLE];
  logic                w_hit  [ROT_PER_CYCLE];
  logic [IMM8_W-1:0]   w_imm8 [ROT_PER_CYCLE];
`ifdef IMM_ENC_INVERT_EN
  logic                w_hit_n  [ROT_PER_CYCLE];
  logic [IMM8_W-1:0]   w_imm8_n [ROT_PER_CYCLE];
  logic                r_inverted;
`endif

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_k == K_LAST);

  for (genvar gi = 0; gi < ROT_PER_CYCLE; gi++) begin : g_chk
    assign w_rot[gi] = r_k + ROT_W'(gi);
    imm_rot_check u_chk (
      .i_value (r_value),
      .i_rot   (w_rot[gi]),
      .o_hit   (w_hit[gi]),
      .o_imm8  (w_imm8[gi])
    );
`ifdef IMM_ENC_INVERT_EN
    imm_rot_check u_chk_n (
      .i_value (~r_value),
      .i_rot   (w_rot[gi]),
      .o_hit   (w_hit_n[gi]),
      .o_imm8  (w_imm8_n[gi])
    );
`endif
  end

  // Lowest-index pick within the current group; a plain hit beats an inverted one at the same r.
  always_comb begin
    w_any      = 1'b0;
    w_sel_rot  = '0;
    w_sel_imm8 = '0;
    w_sel_inv  = 1'b0;
    for (int i = 0; i < ROT_PER_CYCLE; i++) begin
      if (!w_any && w_hit[i]) begin
        w_any      = 1'b1;
        w_sel_rot  = w_rot[i];
        w_sel_imm8 = w_imm8[i];
        w_sel_inv  = 1'b0;
`ifdef IMM_ENC_INVERT_EN
      end else if (!w_any && w_hit_n[i]) begin
        w_any      = 1'b1;
        w_sel_rot  = w_rot[i];
        w_sel_imm8 = w_imm8_n[i];
        w_sel_inv  = 1'b1;
`endif
      end else begin
        w_any      = w_any;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept, search until hit or last group, hold until consumed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = w_accept ? ST_SEARCH : ST_IDLE;
      ST_SEARCH: w_next_state = (w_any || w_last) ? ST_DONE : ST_SEARCH;
      ST_DONE:   w_next_state = out_ready ? ST_IDLE : ST_DONE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Datapath: latch request, step the rotation counter, capture the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value     <= 32'd0;
      r_k         <= '0;
      r_encodable <= 1'b0;
      r_rot       <= '0;
      r_imm8      <= '0;
`ifdef IMM_ENC_INVERT_EN
      r_inverted  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_value <= value;
      r_k     <= '0;
    end else if (r_state == ST_SEARCH) begin
      if (w_any) begin
        r_encodable <= 1'b1;
        r_rot       <= w_sel_rot;
        r_imm8      <= w_sel_imm8;
`ifdef IMM_ENC_INVERT_EN
        r_inverted  <= w_sel_inv;
`endif
      end else if (w_last) begin
        r_encodable <= 1'b0;
        r_rot       <= '0;
        r_imm8      <= '0;
        r_k         <= '0;
`ifdef IMM_ENC_INVERT_EN
        r_inverted  <= 1'b0;
`endif
      end else begin
        r_k <= r_k + K_STEP;
      end
    end else begin
      r_k <= r_k;
    end
  end

  assign encodable     = r_encodable;
  assign rotate_imm    = r_rot;
  assign immed_8       = r_imm8;
  assign shift_operand = {r_rot, r_imm8};
`ifdef IMM_ENC_INVERT_EN
  assign inverted      = r_inverted;
`else
  assign inverted      = 1'b0;
  logic w_unused;
  assign w_unused      = w_sel_inv;
`endif

endmodule
